// File: rtl/counter_down15.sv
// counter_down15 -- loadable down counter (counts MAX -> 0) with wrap or
// one-shot stop, a terminal-count pulse and a registered DONE flag.
//
// Optional feature macro: COUNTER_DOWN_SEVSEG_EN
//   defined   -> adds the seg[6:0] port with a combinational hex decode of out
//   undefined -> no seg port and no decode logic; counting is identical
//
// Per-edge priority is RESET > LOAD > EN. All outputs except seg are registered.

module counter_down15 #(
    parameter int WIDTH = 4
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             EN,
    input  logic             LOAD,
    input  logic [WIDTH-1:0] LOAD_VAL,
    input  logic             MODE,
    output logic [WIDTH-1:0] out,
    output logic             TC,
`ifdef COUNTER_DOWN_SEVSEG_EN
    output logic             DONE,
    output logic [6:0]       seg
`else
    output logic             DONE
`endif
);

    localparam logic [WIDTH-1:0] CNT_MAX  = '1;
    localparam logic [WIDTH-1:0] CNT_ZERO = '0;
    localparam logic [WIDTH-1:0] CNT_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

    // COUNT: normal counting. HOLD: one-shot parked at zero until LOAD/RESET.
    typedef enum logic [0:0] {
        ST_COUNT = 1'b0,
        ST_HOLD  = 1'b1
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_count;
    logic             r_tc;
    logic             r_done;

    state_t           w_state_nxt;
    logic [WIDTH-1:0] w_count_nxt;
    logic             w_tc_nxt;
    logic             w_done_nxt;

    // Register the state together with every registered output.
    always_ff @(posedge CLK) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples the pre-edge values, independent of statement order.
        if (RESET) begin
            r_state <= ST_COUNT;
            r_count <= CNT_MAX;
            r_tc    <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_count <= w_count_nxt;
            r_tc    <= w_tc_nxt;
            r_done  <= w_done_nxt;
        end
    end

    // Next-state and next-output decision: LOAD first, then EN within the state.
    always_comb begin
        // NOTE: every target gets a default first, so no path can leave a value
        // unassigned and infer a latch.
        w_state_nxt = r_state;
        w_count_nxt = r_count;
        w_tc_nxt    = 1'b0;
        w_done_nxt  = r_done;

        if (LOAD) begin
            // A preset never raises TC; a zero preset in one-shot parks at once.
            w_count_nxt = LOAD_VAL;
            if ((LOAD_VAL == CNT_ZERO) && MODE) begin
                w_state_nxt = ST_HOLD;
                w_done_nxt  = 1'b1;
            end else begin
                w_state_nxt = ST_COUNT;
                w_done_nxt  = 1'b0;
            end
        end else begin
            unique case (r_state)
                ST_COUNT: begin
                    w_done_nxt = 1'b0;
                    if (EN) begin
                        if (r_count > CNT_ONE) begin
                            w_count_nxt = r_count - CNT_ONE;
                        end else if (r_count == CNT_ONE) begin
                            // The only transition that produces a terminal count.
                            w_count_nxt = CNT_ZERO;
                            w_tc_nxt    = 1'b1;
                            if (MODE) begin
                                w_state_nxt = ST_HOLD;
                                w_done_nxt  = 1'b1;
                            end
                        end else if (!MODE) begin
                            // Sitting at zero in wrap mode: roll over silently.
                            w_count_nxt = CNT_MAX;
                        end else begin
                            // Zero reached earlier in wrap mode, then MODE went
                            // high: park without a second TC.
                            w_state_nxt = ST_HOLD;
                            w_done_nxt  = 1'b1;
                        end
                    end
                end
                ST_HOLD: begin
                    w_count_nxt = CNT_ZERO;
                    w_done_nxt  = 1'b1;
                end
                default: begin
                    w_state_nxt = ST_COUNT;
                    w_done_nxt  = 1'b0;
                end
            endcase
        end
    end

    assign out  = r_count;
    assign TC   = r_tc;
    assign DONE = r_done;

`ifdef COUNTER_DOWN_SEVSEG_EN
    logic [3:0] w_nibble;

    generate
        if (WIDTH >= 4) begin : g_nib_slice
            assign w_nibble = r_count[3:0];
        end else begin : g_nib_pad
            assign w_nibble = {{(4-WIDTH){1'b0}}, r_count};
        end
    endgenerate

    // Active-high hex decode of the low nibble, seg[6]=a ... seg[0]=g.
    always_comb begin
        seg = 7'b0000000;
        unique case (w_nibble)
            4'h0: seg = 7'b1111110;
            4'h1: seg = 7'b0110000;
            4'h2: seg = 7'b1101101;
            4'h3: seg = 7'b1111001;
            4'h4: seg = 7'b0110011;
            4'h5: seg = 7'b1011011;
            4'h6: seg = 7'b1011111;
            4'h7: seg = 7'b1110000;
            4'h8: seg = 7'b1111111;
            4'h9: seg = 7'b1111011;
            4'hA: seg = 7'b1110111;
            4'hB: seg = 7'b0011111;
            4'hC: seg = 7'b1001110;
            4'hD: seg = 7'b0111101;
            4'hE: seg = 7'b1001111;
            4'hF: seg = 7'b1000111;
            default: seg = 7'b0000000;
        endcase
    end
`else
    // No display decode in this build; the counter is unaffected.
`endif

endmodule
